// File: rtl/extinguisher_controller.sv
// Fire-extinguisher sequencer: qualify request, warn, discharge, cool down, repeat, lock out.
// Optional manual abort is compiled in when EXT_ABORT_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a fire request
// CONFIRM   | request must stay high for CONFIRM_CYCLES edges
// WARN      | siren only, valve closed
// DISCHARGE | siren and valve open for one shot
// COOLDOWN  | valve closed, decides repeat / lockout / idle
// LOCKOUT   | shot limit reached, waits for operator acknowledge
module extinguisher_controller #(
  parameter int CONFIRM_CYCLES   = 4,
  parameter int WARN_CYCLES      = 8,
  parameter int DISCHARGE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES  = 8,
  parameter int MAX_SHOTS        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fire_extinguisher,
  input  logic       abort,
  input  logic       reset_ack,
  output logic       siren,
  output logic       valve,
  output logic       busy,
  output logic       lockout,
  output logic [3:0] discharge_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIRM,
    S_WARN,
    S_DISCHARGE,
    S_COOLDOWN,
    S_LOCKOUT
  } state_t;

  localparam logic [15:0] CONFIRM_LAST   = 16'(CONFIRM_CYCLES - 1);
  localparam logic [15:0] WARN_LAST      = 16'(WARN_CYCLES - 1);
  localparam logic [15:0] DISCHARGE_LAST = 16'(DISCHARGE_CYCLES - 1);
  localparam logic [15:0] COOLDOWN_LAST  = 16'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]  SHOT_LIMIT     = 4'(MAX_SHOTS);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [3:0]  shot_cnt;

`ifndef EXT_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fire_extinguisher) state_nxt = S_CONFIRM;
      end
      S_CONFIRM: begin
        if (!fire_extinguisher)         state_nxt = S_IDLE;
        else if (cnt == CONFIRM_LAST)   state_nxt = S_WARN;
      end
      S_WARN: begin
        if (cnt == WARN_LAST) state_nxt = S_DISCHARGE;
      end
      S_DISCHARGE: begin
        if (cnt == DISCHARGE_LAST) state_nxt = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (cnt == COOLDOWN_LAST) begin
          if (shot_cnt == SHOT_LIMIT)  state_nxt = S_LOCKOUT;
          else if (fire_extinguisher)  state_nxt = S_WARN;
          else                         state_nxt = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (reset_ack && !fire_extinguisher) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef EXT_ABORT_EN
    // Abort overrides any timer expiry in the same cycle.
    if (abort) begin
      case (state)
        S_CONFIRM, S_WARN: state_nxt = S_IDLE;
        S_DISCHARGE:       state_nxt = S_COOLDOWN;
        default:           ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= 16'd0;
      shot_cnt        <= 4'd0;
      discharge_count <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE || state == S_LOCKOUT)
        cnt <= 16'd0;
      else
        cnt <= cnt + 16'd1;
      if (state_nxt == S_DISCHARGE && state != S_DISCHARGE) begin
        shot_cnt <= shot_cnt + 4'd1;
        if (discharge_count != 4'hF) discharge_count <= discharge_count + 4'd1;
      end else if (state_nxt == S_IDLE && state != S_IDLE) begin
        shot_cnt <= 4'd0;
      end
    end
  end

  assign busy    = (state != S_IDLE);
  assign siren   = (state == S_WARN) || (state == S_DISCHARGE) ||
                   (state == S_COOLDOWN) || (state == S_LOCKOUT);
  assign valve   = (state == S_DISCHARGE);
  assign lockout = (state == S_LOCKOUT);

endmodule
